// File: rtl/dot_product_sequencer_if.sv
// Element stream, multiply-add unit link and result port of the dot-product sequencer.
// The master modport is the sequencer's view; slave is the view of whatever surrounds it.
interface dot_product_sequencer_if #(
  parameter int unsigned IN_M_WIDTH = 10,
  parameter int unsigned ACC_WIDTH  = 24,
  parameter int unsigned CNT_WIDTH  = 8
);
  // element input stream
  logic                         in_valid;
  logic                         in_ready;
  logic signed [IN_M_WIDTH-1:0] in_a;
  logic signed [IN_M_WIDTH-1:0] in_b;
  logic                         in_last;
  // multiply-add unit link
  logic                         mac_in_ready;
  logic signed [IN_M_WIDTH-1:0] mac_a;
  logic signed [IN_M_WIDTH-1:0] mac_b;
  logic signed [ACC_WIDTH-1:0]  mac_c;
  logic signed [ACC_WIDTH-1:0]  mac_res;
  logic                         mac_out_ready;
  // held result
  logic                         out_valid;
  logic                         out_ready;
  logic signed [ACC_WIDTH-1:0]  out_sum;
  logic [CNT_WIDTH-1:0]         out_count;
  logic                         err;

  modport master (
    input  in_valid, in_a, in_b, in_last, mac_res, mac_out_ready, out_ready,
    output in_ready, mac_in_ready, mac_a, mac_b, mac_c, out_valid, out_sum, out_count, err
  );

  modport slave (
    output in_valid, in_a, in_b, in_last, mac_res, mac_out_ready, out_ready,
    input  in_ready, mac_in_ready, mac_a, mac_b, mac_c, out_valid, out_sum, out_count, err
  );
endinterface

// File: rtl/dot_product_sequencer.sv
// Feeds signed operand pairs into a pipelined multiply-add unit and accumulates a dot product
// per vector by looping the accumulator back through the unit's addend port.
module dot_product_sequencer #(
  parameter int unsigned IN_M_WIDTH  = 10,
  parameter int unsigned ACC_WIDTH   = 24,
  parameter int unsigned MAC_LATENCY = 0,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input logic                     clk,
  input logic                     reset,
  input logic                     enable,
  dot_product_sequencer_if.master bus
);

  // Wait counter only needs to reach MAC_LATENCY.
  localparam int unsigned WaitW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY + 1) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MAC_LATENCY);

  typedef enum logic [1:0] {StIssue, StWait, StDone} state_e;

  state_e                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0]        count_q, count_d;
  logic                        last_q, last_d;
  logic                        err_q, err_d;
  logic [WaitW-1:0]            wait_q, wait_d;

  logic in_ready_c;
  logic accept;

  assign in_ready_c = (state_q == StIssue) && enable && !reset;
  assign accept     = bus.in_valid && in_ready_c;

  // State register; everything holds while enable is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIssue;
    end else if (enable) begin
      state_q <= state_d;
    end
  end

  // Accumulator, element count, latched last flag, sticky error and wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      wait_q  <= '0;
    end else if (enable) begin
      acc_q   <= acc_d;
      count_q <= count_d;
      last_q  <= last_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    last_d  = last_q;
    err_d   = err_q;
    wait_d  = wait_q;
    unique case (state_q)
      StIssue: begin
        // With a pipelined unit nothing can legitimately come back while issuing.
        if ((MAC_LATENCY != 0) && bus.mac_out_ready) begin
          err_d = 1'b1;
        end
        if (accept) begin
          count_d = count_q + CNT_WIDTH'(1);
          last_d  = bus.in_last;
          if (MAC_LATENCY == 0) begin
            acc_d   = bus.mac_res;
            state_d = bus.in_last ? StDone : StIssue;
          end else begin
            wait_d  = WaitW'(1);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (wait_q == WaitLast) begin
          // A missing return drops the element but keeps its count.
          if (bus.mac_out_ready) begin
            acc_d = bus.mac_res;
          end else begin
            err_d = 1'b1;
          end
          state_d = last_q ? StDone : StIssue;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StDone: begin
        if (bus.mac_out_ready) begin
          err_d = 1'b1;
        end
        if (bus.out_ready) begin
          acc_d   = '0;
          count_d = '0;
          state_d = StIssue;
        end
      end
      default: state_d = StIssue;
    endcase
  end

  // Outputs: operands pass straight through, addend is the held accumulator.
  always_comb begin
    bus.in_ready     = in_ready_c;
    bus.mac_in_ready = accept;
    bus.mac_a        = bus.in_a;
    bus.mac_b        = bus.in_b;
    bus.mac_c        = acc_q;
    bus.out_valid    = (state_q == StDone);
    bus.out_sum      = acc_q;
    bus.out_count    = count_q;
    bus.err          = err_q;
  end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: one instance with a combinational unit (latency 0, 24-bit
// accumulator) and one with a 2-stage behavioural unit (latency 2, 20-bit accumulator).
module tb_dot_product_sequencer;
  localparam int unsigned InW  = 10;
  localparam int unsigned Acc0 = 24;
  localparam int unsigned Acc1 = 20;
  localparam int unsigned CntW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dot_product_sequencer_if #(.IN_M_WIDTH(InW), .ACC_WIDTH(Acc0), .CNT_WIDTH(CntW)) if0 ();
  dot_product_sequencer_if #(.IN_M_WIDTH(InW), .ACC_WIDTH(Acc1), .CNT_WIDTH(CntW)) if1 ();

  // per-instance stimulus
  logic                  en_d[2], valid_d[2], last_d[2], oready_d[2], force_d[2];
  logic signed [InW-1:0] a_d[2], b_d[2];
  logic                  drop_q;

  // per-instance observations, sums sign-extended to 24 bits
  logic              ir_w[2], mir_w[2], ov_w[2], err_w[2];
  logic signed [23:0] sum_w[2], macc_w[2];
  logic [CntW-1:0]   cnt_w[2];

  dot_product_sequencer #(
    .IN_M_WIDTH(InW), .ACC_WIDTH(Acc0), .MAC_LATENCY(0), .CNT_WIDTH(CntW)
  ) dut0 (.clk(clk), .reset(reset), .enable(en_d[0]), .bus(if0.master));

  dot_product_sequencer #(
    .IN_M_WIDTH(InW), .ACC_WIDTH(Acc1), .MAC_LATENCY(2), .CNT_WIDTH(CntW)
  ) dut1 (.clk(clk), .reset(reset), .enable(en_d[1]), .bus(if1.master));

  assign if0.in_valid  = valid_d[0];
  assign if0.in_a      = a_d[0];
  assign if0.in_b      = b_d[0];
  assign if0.in_last   = last_d[0];
  assign if0.out_ready = oready_d[0];
  assign if1.in_valid  = valid_d[1];
  assign if1.in_a      = a_d[1];
  assign if1.in_b      = b_d[1];
  assign if1.in_last   = last_d[1];
  assign if1.out_ready = oready_d[1];

  assign ir_w[0]   = if0.in_ready;
  assign ir_w[1]   = if1.in_ready;
  assign mir_w[0]  = if0.mac_in_ready;
  assign mir_w[1]  = if1.mac_in_ready;
  assign ov_w[0]   = if0.out_valid;
  assign ov_w[1]   = if1.out_valid;
  assign err_w[0]  = if0.err;
  assign err_w[1]  = if1.err;
  assign sum_w[0]  = if0.out_sum;
  assign sum_w[1]  = {{4{if1.out_sum[Acc1-1]}}, if1.out_sum};
  assign macc_w[0] = if0.mac_c;
  assign macc_w[1] = {{4{if1.mac_c[Acc1-1]}}, if1.mac_c};
  assign cnt_w[0]  = if0.out_count;
  assign cnt_w[1]  = if1.out_count;

  // Latency-0 unit: result and strobe in the issue cycle.
  assign if0.mac_res       = if0.mac_c + if0.mac_a * if0.mac_b;
  assign if0.mac_out_ready = if0.mac_in_ready | force_d[0];

  // Latency-2 unit: input register then product register, addend added at the output.
  logic signed [Acc1-1:0] p1p, p2p;
  logic                   p1v, p2v, p1x, p2x;
  always @(posedge clk) begin
    if (reset) begin
      p1v <= 1'b0; p2v <= 1'b0; p1x <= 1'b0; p2x <= 1'b0; p1p <= '0; p2p <= '0;
    end else if (en_d[1]) begin
      p1v <= if1.mac_in_ready;
      p1x <= drop_q;
      p1p <= if1.mac_a * if1.mac_b;
      p2v <= p1v;
      p2x <= p1x;
      p2p <= p1p;
    end
  end
  assign if1.mac_res       = if1.mac_c + p2p;
  assign if1.mac_out_ready = (p2v & ~p2x) | force_d[1];

  int tests = 0;
  int fails = 0;

  typedef struct {
    int a[4];
    int b[4];
    int len;
    int e24;
    int e20;
  } vec_t;
  vec_t tbl[4];

  int va[8];
  int vb[8];
  int vlen;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint wrapw(input longint v, input int w);
    longint m;
    m = v & ((longint'(1) << w) - 1);
    if (m >= (longint'(1) << (w - 1))) m = m - (longint'(1) << w);
    return m;
  endfunction

  function automatic int lat(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic int accw(input int d);
    return (d == 0) ? Acc0 : Acc1;
  endfunction

  // mode 0: always enabled, 1: random, 2: disabled in raw cycles 1..3
  function automatic bit pick_en(input int mode, input int raw);
    if (mode == 1) return ($urandom_range(0, 3) != 0);
    if (mode == 2) return !(raw >= 1 && raw <= 3);
    return 1'b1;
  endfunction

  // Sends va/vb[0..vlen-1] to instance d, checks timing in enabled cycles, the held result and
  // the back-to-back handshake. wk selects an element whose unit return is withheld.
  task automatic run_vec(input int d, input int mode, input int delay, input int wk,
                         input bit spur, input longint exp_sum, input int exp_cnt,
                         input bit exp_err);
    int     k = 0;
    int     ecyc = 0;
    int     raw = 0;
    int     budget = 0;
    int     l = lat(d);
    longint part = 0;
    bit     en;
    bit     seen = 1'b0;
    while (k < vlen && raw < 300) begin
      en        = pick_en(mode, raw);
      en_d[d]   = en;
      valid_d[d] = 1'b1;
      a_d[d]    = InW'(va[k]);
      b_d[d]    = InW'(vb[k]);
      last_d[d] = (k == vlen - 1);
      drop_q    = (d == 1) && (k == wk);
      #1;
      if (!en) chk("in_ready_while_disabled", ir_w[d], 0);
      if (ir_w[d]) begin
        chk("accept_cycle", ecyc, k * (l + 1));
        chk("mac_in_ready_on_accept", mir_w[d], 1);
        chk("mac_c_partial_sum", macc_w[d], wrapw(part, accw(d)));
        chk("err_during_vector", err_w[d], (wk >= 0 && k > wk) ? 1 : 0);
        if (k != wk) part += longint'(va[k]) * longint'(vb[k]);
        k++;
      end
      if (en) ecyc++;
      raw++;
      @(posedge clk); #1;
    end
    valid_d[d] = 1'b0;
    last_d[d]  = 1'b0;
    drop_q     = 1'b0;
    if (k < vlen) chk("accept_timeout", k, vlen);
    while (!seen && budget < 100) begin
      en      = pick_en(mode, raw);
      en_d[d] = en;
      #1;
      if (ov_w[d]) begin
        seen = 1'b1;
        chk("result_latency", ecyc, (vlen - 1) * (l + 1) + l + 1);
      end else begin
        if (en) ecyc++;
        raw++;
        budget++;
        @(posedge clk); #1;
      end
    end
    if (!seen) chk("out_valid_timeout", 0, 1);
    for (int i = 0; i < delay; i++) begin
      en_d[d]     = (spur && i == 0) ? 1'b1 : pick_en(mode, raw);
      oready_d[d] = 1'b0;
      force_d[d]  = spur && (i == 0);
      #1;
      chk("hold_out_valid", ov_w[d], 1);
      chk("hold_out_sum", sum_w[d], exp_sum);
      chk("hold_in_ready", ir_w[d], 0);
      raw++;
      @(posedge clk); #1;
      force_d[d] = 1'b0;
    end
    en_d[d]     = 1'b1;
    oready_d[d] = 1'b1;
    #1;
    chk("out_valid", ov_w[d], 1);
    chk("out_sum", sum_w[d], exp_sum);
    chk("out_count", cnt_w[d], exp_cnt % (1 << CntW));
    chk("err", err_w[d], exp_err);
    @(posedge clk); #1;
    oready_d[d] = 1'b0;
    #1;
    chk("in_ready_after_handshake", ir_w[d], 1);
    chk("out_valid_after_handshake", ov_w[d], 0);
  endtask

  task automatic load_tbl(input int i);
    vlen = tbl[i].len;
    for (int j = 0; j < 4; j++) begin
      va[j] = tbl[i].a[j];
      vb[j] = tbl[i].b[j];
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_out_valid"}, ov_w[d], 0);
      chk({tag, "_out_sum"}, sum_w[d], 0);
      chk({tag, "_out_count"}, cnt_w[d], 0);
      chk({tag, "_err"}, err_w[d], 0);
      chk({tag, "_mac_c"}, macc_w[d], 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint s;
    tbl[0].a = '{3, -2, 7, 0};        tbl[0].b = '{4, 5, -1, 0};
    tbl[0].len = 3;  tbl[0].e24 = -5;     tbl[0].e20 = -5;
    tbl[1].a = '{1, 0, 0, 0};         tbl[1].b = '{1, 0, 0, 0};
    tbl[1].len = 1;  tbl[1].e24 = 1;      tbl[1].e20 = 1;
    tbl[2].a = '{-512, -512, 0, 0};   tbl[2].b = '{-512, -512, 0, 0};
    tbl[2].len = 2;  tbl[2].e24 = 524288; tbl[2].e20 = -524288;
    tbl[3].a = '{511, 511, 0, -1};    tbl[3].b = '{511, -512, 5, -1};
    tbl[3].len = 4;  tbl[3].e24 = -510;   tbl[3].e20 = -510;

    drop_q = 1'b0;
    for (int d = 0; d < 2; d++) begin
      en_d[d] = 1'b1; valid_d[d] = 1'b1; last_d[d] = 1'b0; oready_d[d] = 1'b0;
      force_d[d] = 1'b0; a_d[d] = '0; b_d[d] = '0;
    end
    reset = 1'b1;
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("in_ready_in_reset", ir_w[d], 0);
      chk("mac_in_ready_in_reset", mir_w[d], 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    valid_d[0] = 1'b0;
    valid_d[1] = 1'b0;
    #1;
    check_reset_values("reset");

    // directed table, full enable; first vector held 5 cycles before the handshake
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        load_tbl(i);
        run_vec(d, 0, (i == 0) ? 5 : 1, -1, 1'b0, (d == 0) ? tbl[i].e24 : tbl[i].e20,
                tbl[i].len, 1'b0);
      end
    end

    // enable low for 3 cycles during WAIT of the first element
    load_tbl(0);
    run_vec(1, 2, 1, -1, 1'b0, -5, 3, 1'b0);

    // randomized vectors against the arithmetic reference
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 12; r++) begin
        vlen = int'($urandom_range(1, 6));
        s = 0;
        for (int j = 0; j < vlen; j++) begin
          va[j] = int'($urandom_range(0, 1023)) - 512;
          vb[j] = int'($urandom_range(0, 1023)) - 512;
          s += longint'(va[j]) * longint'(vb[j]);
        end
        run_vec(d, 1, int'($urandom_range(0, 3)), -1, 1'b0, wrapw(s, accw(d)), vlen, 1'b0);
      end
    end

    // unit return withheld for the middle element: dropped, counted, err raised
    vlen = 3;
    va[0] = 2; vb[0] = 3; va[1] = 5; vb[1] = 5; va[2] = 1; vb[2] = 1;
    run_vec(1, 0, 1, 1, 1'b0, 7, 3, 1'b1);

    // reset in WAIT cycle 1 abandons the element and clears err
    en_d[1] = 1'b1; valid_d[1] = 1'b1; a_d[1] = 10'sd9; b_d[1] = 10'sd9; last_d[1] = 1'b0;
    #1;
    chk("midwait_accept", ir_w[1], 1);
    @(posedge clk); #1;
    valid_d[1] = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_reset_values("midwait_reset");
    chk("midwait_mac_in_ready", mir_w[1], 0);

    // spurious unit strobe while a result is held
    vlen = 1; va[0] = 1; vb[0] = 1;
    run_vec(1, 0, 3, -1, 1'b1, 1, 1, 1'b1);
    run_vec(0, 0, 3, -1, 1'b1, 1, 1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dot_product_sequencer.md
# dot_product_sequencer

Sequences a stream of signed operand pairs into an attached pipelined multiply-add unit and accumulates a dot product over each vector, closing the feedback loop through the unit's addend port. It sits directly upstream of the multiply-add stage, drives its A/B/C operands and input strobe, and consumes its result and output strobe. It presents a valid/ready element input and a held result output to the surrounding linear-algebra datapath.

## Interface
- IN_M_WIDTH, 10: signed operand width; equals the multiply-add unit's multiplier input width.
- ACC_WIDTH, 24: signed accumulator, addend and result width; must be ≥ 2*IN_M_WIDTH.
- MAC_LATENCY, 0: total pipeline latency of the attached unit (input-register depth plus multiplier pipe depth), in enabled cycles.
- CNT_WIDTH, 8: element-counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- enable  in  1  clock enable; the same signal drives the attached unit's enable
- in_valid  in  1  element present
- in_ready  out  1  element accepted when in_valid & in_ready
- in_a, in_b  in  IN_M_WIDTH  signed operands
- in_last  in  1  final element of the vector
- mac_in_ready  out  1  strobe to the unit's input
- mac_a, mac_b  out  IN_M_WIDTH  operands to the unit
- mac_c  out  ACC_WIDTH  addend to the unit (current accumulator)
- mac_res  in  ACC_WIDTH  unit result
- mac_out_ready  in  1  unit output strobe
- out_valid  out  1  result held
- out_ready  in  1  result consumed
- out_sum  out  ACC_WIDTH  dot product
- out_count  out  CNT_WIDTH  elements in the vector, modulo 2^CNT_WIDTH
- err  out  1  sticky protocol error

## Operation
- State machine:
  - States: ISSUE, WAIT, DONE. Reset state is ISSUE, with acc=0, count=0 and err=0.
  - The state machine advances only when enable=1. While enable=0, all registers hold and in_ready=0, mac_in_ready=0.
- ISSUE:
  - in_ready = enable & !reset.
  - mac_a=in_a and mac_b=in_b combinationally, and mac_c=acc.
  - mac_in_ready = in_valid & in_ready.
  - On accept, count increments and in_last is latched.
- MAC_LATENCY=0:
  - mac_res is valid in the accept cycle: acc<=mac_res.
  - Next state is DONE if in_last, else ISSUE.
- MAC_LATENCY>0:
  - Next state is WAIT. acc holds, so mac_c stays stable for the unit's late addition.
- WAIT:
  - in_ready=0, and a wait counter counts enabled cycles from 1.
  - mac_out_ready must arrive in WAIT cycle MAC_LATENCY; then acc<=mac_res, and next state is DONE if the latched last flag is set, else ISSUE.
  - If WAIT cycle MAC_LATENCY ends without mac_out_ready: set err, discard the element (acc unchanged, count keeps the increment), and go to ISSUE, or to DONE if the latched last flag is set.
- DONE:
  - out_valid=1, out_sum=acc, out_count=count, in_ready=0.
  - On out_ready & enable: acc<=0, count<=0, go to ISSUE.
- Errors: mac_out_ready sampled high in ISSUE (MAC_LATENCY>0) or in DONE sets err. err clears only on reset.
- Arithmetic: the addition happens in the unit, and acc wraps modulo 2^ACC_WIDTH. count wraps modulo 2^CNT_WIDTH.
- Reset mid-operation: any in-flight element is abandoned. The attached unit receives the same reset.

## Timing
- Reset values: out_valid=0, out_sum=0, out_count=0, err=0, in_ready=0 and mac_in_ready=0 during the reset cycle, mac_c=0.
- Throughput: 1 element/cycle when MAC_LATENCY=0; 1 element per MAC_LATENCY+1 enabled cycles otherwise.
- Result latency: out_valid rises MAC_LATENCY+1 enabled cycles after the last element is accepted, and holds until out_ready.
- out_sum and out_count stay stable while out_valid=1.
- Back-to-back vectors: in_ready rises the cycle after the out_ready handshake.
- enable low in any state stretches all timing by the number of disabled cycles; no strobe is lost.

## Test plan
- MAC_LATENCY=0, vector (3,4),(−2,5),(7,−1 last) offered continuously -> accepted in cycles 0,1,2; out_valid in cycle 3 with out_sum=−5, out_count=3.
- MAC_LATENCY=2, same vector with a behavioural 2-cycle unit -> accepts in cycles 0,3,6; out_valid from cycle 9 with out_sum=−5; err=0.
- out_ready low for 5 cycles in DONE -> out_sum stays −5 and in_ready=0; after the handshake, next vector (1,1 last) -> out_sum=1, out_count=1.
- MAC_LATENCY=2, enable low for 3 cycles during WAIT -> the return is accepted in a delayed but correct cycle; final sum matches; err=0.
- IN_M_WIDTH=10, ACC_WIDTH=20: (−512,−512),(−512,−512 last) -> out_sum=−524288 (wrapped).
- MAC_LATENCY=2 with mac_out_ready withheld -> err=1 after 2 WAIT cycles, FSM back in ISSUE, acc unchanged. A spurious mac_out_ready in DONE also sets err. reset asserted mid-WAIT -> all outputs return to their reset values the next cycle.
